// File: rtl/pcie_rx_tag_ctrl.sv
// pcie_rx_tag_ctrl: tracks outstanding read tags, places completion beats into a reorder FIFO and retires requests in order
module pcie_rx_tag_ctrl #(
  parameter int C_PCIE_DATA_WIDTH  = 512,
  parameter int P_FIFO_DEPTH_WIDTH = 9,
  parameter int P_SLOT_WIDTH       = 3,
  parameter int P_TAG_WIDTH        = 4,
  parameter int P_LEN_WIDTH        = 5,
  parameter int P_TMO_WIDTH        = 16
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst,
  input  logic                            pcie_tag_alloc,
  input  logic [7:0]                      pcie_alloc_tag,
  input  logic [P_LEN_WIDTH-1:0]          pcie_tag_alloc_len,
  output logic                            pcie_tag_full_n,
  input  logic [7:0]                      cpld_fifo_tag,
  input  logic [C_PCIE_DATA_WIDTH-1:0]    cpld_fifo_wr_data,
  input  logic                            cpld_fifo_wr_en,
  input  logic                            cpld_fifo_tag_last,
  input  logic [P_TMO_WIDTH-1:0]          tmo_limit,
  output logic                            fifo_wr_en,
  output logic [P_FIFO_DEPTH_WIDTH-1:0]   fifo_wr_addr,
  output logic [C_PCIE_DATA_WIDTH-1:0]    fifo_wr_data,
  output logic [P_FIFO_DEPTH_WIDTH:0]     rear_full_addr,
  output logic [P_FIFO_DEPTH_WIDTH:0]     rear_addr,
  output logic                            cpld_unexp,
  output logic                            tag_tmo,
  output logic [7:0]                      tag_tmo_tag,
  output logic [P_SLOT_WIDTH:0]           slots_busy
);
  localparam int NS = 1 << P_SLOT_WIDTH;
  localparam int AW = P_FIFO_DEPTH_WIDTH + 1;
  logic [P_SLOT_WIDTH:0] rear, front;
  logic [P_SLOT_WIDTH-1:0] rs, fs, hit_idx, rep_idx;
  logic [NS-1:0] valid, done, pend, hit_vec, exp_vec, rep_vec;
  logic [7:0] tag [NS];
  logic [7:0] ptag [NS];
  logic [AW-1:0] addr [NS];
  logic [AW-1:0] end_a [NS];
  logic [P_TMO_WIDTH-1:0] cnt [NS];
  logic hit, rep, full, retire, unused_tag;
  assign rs = rear[P_SLOT_WIDTH-1:0];
  assign fs = front[P_SLOT_WIDTH-1:0];
  assign full = rear[P_SLOT_WIDTH] != front[P_SLOT_WIDTH] && rs == fs;
  assign pcie_tag_full_n = ~full;
  assign slots_busy = rear - front;
  assign retire = valid[fs] && done[fs];
  assign unused_tag = ^cpld_fifo_tag;
  always_comb begin
    hit_vec = '0;
    exp_vec = '0;
    hit_idx = '0;
    rep_idx = '0;
    for (int i = 0; i < NS; i++)
      hit_vec[i] = valid[i] && !done[i] && tag[i][P_TAG_WIDTH-1:0] == cpld_fifo_tag[P_TAG_WIDTH-1:0];
    for (int i = NS - 1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = P_SLOT_WIDTH'(i);
    hit = cpld_fifo_wr_en && |hit_vec;
    for (int i = 0; i < NS; i++)
      exp_vec[i] = valid[i] && !done[i] && tmo_limit != '0 &&
                   ({1'b0, cnt[i]} + 1'b1 >= {1'b0, tmo_limit}) &&
                   !(hit && cpld_fifo_tag_last && hit_idx == P_SLOT_WIDTH'(i));
    rep_vec = pend | exp_vec;
    for (int i = NS - 1; i >= 0; i--)
      if (rep_vec[i]) rep_idx = P_SLOT_WIDTH'(i);
    rep = |rep_vec;
  end
  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      rear           <= '0;
      front          <= '0;
      rear_full_addr <= '0;
      rear_addr      <= '0;
      valid          <= '0;
      done           <= '0;
      pend           <= '0;
      fifo_wr_en     <= 1'b0;
      fifo_wr_addr   <= '0;
      cpld_unexp     <= 1'b0;
      tag_tmo        <= 1'b0;
      tag_tmo_tag    <= '0;
    end else begin
      fifo_wr_en <= hit;
      cpld_unexp <= cpld_fifo_wr_en && !hit;
      tag_tmo    <= rep;
      if (rep) tag_tmo_tag <= pend[rep_idx] ? ptag[rep_idx] : tag[rep_idx];
      pend <= rep_vec & ~(NS'(rep) << rep_idx);
      for (int i = 0; i < NS; i++) begin
        if (valid[i] && !done[i] && tmo_limit != '0) cnt[i] <= cnt[i] + 1'b1;
        if (exp_vec[i]) begin
          done[i] <= 1'b1;
          ptag[i] <= tag[i];
        end
      end
      if (hit) begin
        fifo_wr_addr  <= addr[hit_idx][P_FIFO_DEPTH_WIDTH-1:0];
        fifo_wr_data  <= cpld_fifo_wr_data;
        addr[hit_idx] <= addr[hit_idx] + 1'b1;
        if (cpld_fifo_tag_last) done[hit_idx] <= 1'b1;
      end
      if (retire) begin
        valid[fs] <= 1'b0;
        rear_addr <= end_a[fs];
        front     <= front + 1'b1;
      end
      if (pcie_tag_alloc && !full) begin
        valid[rs]      <= 1'b1;
        done[rs]       <= 1'b0;
        tag[rs]        <= pcie_alloc_tag;
        addr[rs]       <= rear_full_addr;
        end_a[rs]      <= rear_full_addr + AW'(pcie_tag_alloc_len);
        cnt[rs]        <= '0;
        rear           <= rear + 1'b1;
        rear_full_addr <= rear_full_addr + AW'(pcie_tag_alloc_len);
      end
    end
  end
endmodule

// File: tb/tb_pcie_rx_tag_ctrl.sv
// tb_pcie_rx_tag_ctrl: directed stimulus checked every cycle against a request-queue model of the tag controller
module tb_pcie_rx_tag_ctrl;
  localparam int DW = 512, FW = 9, SW = 3, TW = 4, LW = 5, TMW = 16, NS = 8, AW = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic alloc = 1'b0, cwe = 1'b0, clast = 1'b0;
  logic [7:0] atag = '0, ctag = '0;
  logic [LW-1:0] alen = '0;
  logic [DW-1:0] cdata = '0;
  logic [TMW-1:0] tmo = '0;
  logic full_n, we, unexp, ttmo;
  logic [FW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] rfa, ra;
  logic [7:0] ttag;
  logic [SW:0] busy;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  pcie_rx_tag_ctrl dut (
    .pcie_user_clk(clk), .pcie_user_rst(rst),
    .pcie_tag_alloc(alloc), .pcie_alloc_tag(atag), .pcie_tag_alloc_len(alen),
    .pcie_tag_full_n(full_n),
    .cpld_fifo_tag(ctag), .cpld_fifo_wr_data(cdata), .cpld_fifo_wr_en(cwe),
    .cpld_fifo_tag_last(clast), .tmo_limit(tmo),
    .fifo_wr_en(we), .fifo_wr_addr(waddr), .fifo_wr_data(wdata),
    .rear_full_addr(rfa), .rear_addr(ra),
    .cpld_unexp(unexp), .tag_tmo(ttmo), .tag_tmo_tag(ttag), .slots_busy(busy)
  );
  typedef struct { int seq; logic [7:0] tag; logic [AW-1:0] addr; logic [AW-1:0] endp; int cnt; bit done; } req_t;
  typedef struct { int slot; logic [7:0] tag; } rep_t;
  req_t q[$];
  rep_t pq[$];
  int seq;
  bit chk_en = 0, e_we, e_unexp, e_tmo, e_full_n;
  logic [FW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic [7:0] e_ttag;
  logic [AW-1:0] m_rfa, m_ra;
  int e_busy;
  always @(posedge clk) begin : model
    req_t r;
    rep_t p;
    int hi, best;
    bit retire, was_full;
    if (rst) begin
      q.delete();
      pq.delete();
      seq = 0; m_rfa = '0; m_ra = '0;
      e_we = 0; e_unexp = 0; e_tmo = 0; e_ttag = '0;
      chk_en = 1;
    end else begin
      was_full = q.size() == NS;
      retire = q.size() > 0 && q[0].done;
      hi = -1;
      for (int i = 0; i < q.size(); i++)
        if (!q[i].done && q[i].tag[TW-1:0] == ctag[TW-1:0] && (hi < 0 || q[i].seq % NS < q[hi].seq % NS)) hi = i;
      e_we = cwe && hi >= 0;
      e_unexp = cwe && hi < 0;
      for (int i = 0; i < q.size(); i++)
        if (!q[i].done && tmo != '0) begin
          r = q[i];
          if (r.cnt + 1 >= int'(tmo) && !(e_we && clast && i == hi)) begin
            r.done = 1;
            p.slot = r.seq % NS;
            p.tag = r.tag;
            pq.push_back(p);
          end else r.cnt++;
          q[i] = r;
        end
      if (e_we) begin
        r = q[hi];
        e_waddr = r.addr[FW-1:0];
        e_wdata = cdata;
        r.addr = r.addr + 1'b1;
        if (clast) r.done = 1;
        q[hi] = r;
      end
      e_tmo = pq.size() > 0;
      if (e_tmo) begin
        best = 0;
        for (int i = 1; i < pq.size(); i++) if (pq[i].slot < pq[best].slot) best = i;
        e_ttag = pq[best].tag;
        pq.delete(best);
      end
      if (retire) begin
        m_ra = q[0].endp;
        void'(q.pop_front());
      end
      if (alloc && !was_full) begin
        r.seq = seq; r.tag = atag; r.addr = m_rfa; r.endp = m_rfa + AW'(alen); r.cnt = 0; r.done = 0;
        q.push_back(r);
        seq++;
        m_rfa = m_rfa + AW'(alen);
      end
    end
    e_busy = q.size();
    e_full_n = q.size() != NS;
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("wr_en", 64'(we), 64'(e_we));
    chk("unexp", 64'(unexp), 64'(e_unexp));
    chk("tag_tmo", 64'(ttmo), 64'(e_tmo));
    chk("tag_tmo_tag", 64'(ttag), 64'(e_ttag));
    chk("full_n", 64'(full_n), 64'(e_full_n));
    chk("slots_busy", 64'(busy), 64'(e_busy));
    chk("rear_addr", 64'(ra), 64'(m_ra));
    chk("rear_full_addr", 64'(rfa), 64'(m_rfa));
    if (e_we) begin
      chk("wr_addr", 64'(waddr), 64'(e_waddr));
      n_run++;
      if (wdata !== e_wdata) begin
        n_fail++;
        $display("FAIL wr_data: got %0h expected %0h", wdata[63:0], e_wdata[63:0]);
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; alloc = 0; cwe = 0; clast = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic do_alloc(input logic [7:0] t, input int l);
    alloc = 1; atag = t; alen = LW'(l);
    tick();
    alloc = 0;
  endtask
  task automatic beat(input logic [7:0] t, input bit l);
    cwe = 1; ctag = t; clast = l; cdata = {16{$urandom}};
    tick();
    cwe = 0; clast = 0;
  endtask
  task automatic lit_reset(input string n);
    chk({n, "_we"}, 64'(we), 0);
    chk({n, "_rear"}, 64'(ra), 0);
    chk({n, "_rfa"}, 64'(rfa), 0);
    chk({n, "_busy"}, 64'(busy), 0);
    chk({n, "_full_n"}, 64'(full_n), 1);
    chk({n, "_unexp"}, 64'(unexp), 0);
    chk({n, "_tmo"}, 64'(ttmo), 0);
    chk({n, "_tmo_tag"}, 64'(ttag), 0);
  endtask
  initial begin
    tick(); tick();
    lit_reset("rst0");
    rst = 0;
    do_alloc(3, 4);
    for (int k = 0; k < 4; k++) begin
      beat(3, k == 3);
      chk("r026_we", 64'(we), 1);
      chk("r026_addr", 64'(waddr), 64'(k));
    end
    chk("r026_rear_early", 64'(ra), 0);
    tick();
    chk("r026_rear", 64'(ra), 4);
    chk("r026_rfa", 64'(rfa), 4);
    do_reset();
    do_alloc(1, 2);
    do_alloc(2, 3);
    beat(2, 0); beat(2, 0); beat(2, 1);
    tick(); tick();
    chk("r027_hold", 64'(ra), 0);
    beat(1, 0); beat(1, 1);
    chk("r027_hold2", 64'(ra), 0);
    tick();
    chk("r027_a", 64'(ra), 2);
    tick();
    chk("r027_b", 64'(ra), 5);
    do_reset();
    for (int i = 0; i < NS; i++) do_alloc(8'(i), 1);
    chk("r028_full_n", 64'(full_n), 0);
    chk("r028_busy", 64'(busy), 8);
    do_alloc(9, 1);
    chk("r028_ign_busy", 64'(busy), 8);
    chk("r028_ign_rfa", 64'(rfa), 8);
    beat(0, 1);
    tick();
    chk("r028_free", 64'(full_n), 1);
    chk("r028_busy7", 64'(busy), 7);
    beat(9, 0);
    chk("r028_unexp", 64'(unexp), 1);
    do_reset();
    tmo = 10;
    do_alloc(5, 2);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("r029_early", 64'(ttmo), 0);
    end
    tick();
    chk("r029_tmo", 64'(ttmo), 1);
    chk("r029_tag", 64'(ttag), 5);
    tick();
    chk("r029_pulse", 64'(ttmo), 0);
    chk("r029_rear", 64'(ra), 2);
    tmo = 0;
    beat(5, 0);
    chk("r029_unexp", 64'(unexp), 1);
    chk("r029_nowr", 64'(we), 0);
    do_reset();
    do_alloc(2, 1);
    do_alloc(8'h12, 1);
    beat(2, 1);
    chk("dup_first", 64'(waddr), 0);
    beat(2, 1);
    chk("dup_second", 64'(waddr), 1);
    for (int i = 7; i <= 10; i++) do_alloc(8'(i), 1);
    tmo = 4;
    tick(); tick(); tick();
    beat(10, 1);
    chk("tmo_last_we", 64'(we), 1);
    chk("tmo_multi0", 64'(ttag), 7);
    tick();
    chk("tmo_multi1", 64'(ttag), 8);
    tick();
    chk("tmo_multi2", 64'(ttag), 9);
    tick();
    chk("tmo_last_wins", 64'(ttmo), 0);
    do_reset();
    tmo = 1;
    for (int i = 0; i < 33; i++) do_alloc(8'(i), 31);
    tick();
    tmo = 0;
    tick(); tick();
    chk("r030_rfa_pre", 64'(rfa), 1023);
    chk("r030_ra_pre", 64'(ra), 1023);
    do_alloc(6, 4);
    chk("r030_rfa_wrap", 64'(rfa), 3);
    beat(6, 0);
    chk("r030_addr511", 64'(waddr), 511);
    beat(6, 0);
    chk("r030_addr0", 64'(waddr), 0);
    rst = 1; cwe = 1; ctag = 6;
    tick();
    lit_reset("r030_rst");
    cwe = 0; rst = 0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_rx_tag_ctrl.md
PCIE_RX_TAG_CTRL -- requirements
Module: pcie_rx_tag_ctrl

Interface
REQ-001 SHALL have parameter C_PCIE_DATA_WIDTH, default 512, completion data beat width.
REQ-002 SHALL have parameter P_FIFO_DEPTH_WIDTH, default 9, reorder-FIFO address width (FIFO holds 2^W beats).
REQ-003 SHALL have parameter P_SLOT_WIDTH, default 3, log2 of tracked slot count (2^N slots, N = 1..5).
REQ-004 SHALL have parameter P_TAG_WIDTH, default 4, low tag bits compared (<= 8).
REQ-005 SHALL have parameter P_LEN_WIDTH, default 5, request length field width, in beats.
REQ-006 SHALL have parameter P_TMO_WIDTH, default 16, timeout counter width.
REQ-007 Ports, clock and reset first; the block has one clock, and reset is synchronous and active-high:
 pcie_user_clk  in  1  clock
 pcie_user_rst  in  1  synchronous active-high reset
 pcie_tag_alloc  in  1  allocate request slot this cycle
 pcie_alloc_tag  in  8  tag of allocated request
 pcie_tag_alloc_len  in  P_LEN_WIDTH  request length in beats
 pcie_tag_full_n  out  1  low when all slots occupied
 cpld_fifo_tag  in  8  tag of current completion beat
 cpld_fifo_wr_data  in  C_PCIE_DATA_WIDTH  completion beat data
 cpld_fifo_wr_en  in  1  completion beat valid
 cpld_fifo_tag_last  in  1  final beat of request, qualified by wr_en
 tmo_limit  in  P_TMO_WIDTH  timeout threshold in cycles; 0 disables
 fifo_wr_en  out  1  FIFO write strobe
 fifo_wr_addr  out  P_FIFO_DEPTH_WIDTH  FIFO write address
 fifo_wr_data  out  C_PCIE_DATA_WIDTH  FIFO write data
 rear_full_addr  out  P_FIFO_DEPTH_WIDTH+1  allocation pointer (space reserved)
 rear_addr  out  P_FIFO_DEPTH_WIDTH+1  committed pointer (data readable below)
 cpld_unexp  out  1  pulse: beat matched no live slot
 tag_tmo  out  1  pulse: slot timed out
 tag_tmo_tag  out  8  tag of timed-out slot, valid with tag_tmo
 slots_busy  out  P_SLOT_WIDTH+1  occupied slot count

Function
REQ-008 Slots SHALL form a ring with binary rear/front pointers of P_SLOT_WIDTH+1 bits; full = MSBs differ and low bits equal; pcie_tag_full_n = ~full, combinational from registers.
REQ-009 On pcie_tag_alloc with not full, slot[rear] SHALL store tag, base = rear_full_addr, and end = rear_full_addr + len; it becomes valid, not done, with timeout count 0; rear++ and rear_full_addr += len (mod 2^(W+1)).
REQ-010 pcie_tag_alloc while full SHALL be ignored: no pointer or slot change.
REQ-011 Lookup SHALL compare cpld_fifo_tag[P_TAG_WIDTH-1:0] against registered slots that are valid and not done; a slot allocated in cycle t SHALL be matchable from t+1.
REQ-012 On a hit in cycle t, fifo_wr_en SHALL be 1 in t+1 with fifo_wr_addr = slot current addr[W-1:0] and fifo_wr_data = beat data; slot addr SHALL increment by 1.
REQ-013 On multiple hits, the lowest slot index SHALL win; only that slot updates.
REQ-014 On a miss with cpld_fifo_wr_en=1, fifo_wr_en SHALL stay 0 and cpld_unexp SHALL pulse in t+1.
REQ-015 A hit beat with cpld_fifo_tag_last=1 SHALL mark the slot done at t+1.
REQ-016 A valid, not-done slot SHALL increment its timeout count each cycle when tmo_limit != 0; on reaching tmo_limit it SHALL be marked done, and tag_tmo/tag_tmo_tag SHALL pulse for one cycle.
REQ-017 If a last beat and timeout expiry coincide on one slot, the last beat SHALL win and no tag_tmo SHALL be raised.
REQ-018 Timeout events on several slots in one cycle SHALL be reported one per cycle, lowest index first, with none lost.
REQ-019 Retirement SHALL be in order: when slot[front] is valid and done, it SHALL be freed next cycle, rear_addr <= slot end (reserved space is skipped on timeout), and front++; at most one retirement per cycle.
REQ-020 Same-cycle alloc and retire SHALL both take effect; slots_busy SHALL equal rear - front (mod 2^(N+1)).
REQ-021 Beats for a done or freed slot SHALL be treated as misses (REQ-014).
REQ-022 Allocation of a tag already live is a caller error; behaviour SHALL follow REQ-013 without hang.
REQ-023 Design SHALL be fully synchronous with no combinational path from any input to any output except none (all outputs registered, full_n from registers).

Reset
REQ-024 While pcie_user_rst=1 at a clock edge: pointers, rear_full_addr, rear_addr, slots_busy = 0; all slots invalid; fifo_wr_en, cpld_unexp, tag_tmo = 0; tag_tmo_tag = 0; pcie_tag_full_n = 1.
REQ-025 Reset mid-operation SHALL discard all slots and pending timeout reports; beats arriving during reset SHALL produce no writes; data and slot payload registers need no reset.

Verification
REQ-026 Alloc tag 3, len 4 at base 0; four beats tag 3, last on 4th -> fifo_wr_addr 0,1,2,3 one cycle after each beat; rear_addr = 4 two cycles after last beat.
REQ-027 Alloc A (len 2) then B (len 3); B completes before A -> rear_addr stays 0 until A done, then 2, then 5 on consecutive cycles.
REQ-028 Allocate 2^N slots with no completions -> pcie_tag_full_n = 0, slots_busy = 2^N; further alloc ignored; one retirement -> full_n = 1.
REQ-029 tmo_limit = 10, alloc tag 5 len 2, no beats -> tag_tmo pulse with tag_tmo_tag = 5 after 10 cycles; rear_addr advances by 2; a later beat tag 5 -> cpld_unexp, no write.
REQ-030 rear_full_addr near 2^(W+1)-1 with len 4 -> wraps to 3; fifo_wr_addr wraps 511 -> 0; reset asserted mid-burst -> all outputs at reset values the next cycle.
